// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the pipelined MIPS core.
// Owns the PC, issues icache reads, and freezes fetch once a HALT word is latched.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = 6'h3F
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] npc_out,
  output logic        valid_out
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;
  logic [31:0] instr_s;
  logic [31:0] npc_s;
  logic        valid_s;

  function automatic logic is_halt(input logic [31:0] word);
    return (word[31:26] == HALT_OP);
  endfunction

  assign pc_plus4_s = pc_r + 32'd4;
  assign target_s   = redirect_pc & 32'hFFFF_FFFC;
  assign imemaddr   = pc_r;
  assign imemREN    = (state_r == RUN);

  // Next-state and IF/ID next values; redirect outranks stall, stall outranks ihit.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    instr_s = instr_out;
    npc_s   = npc_out;
    valid_s = valid_out;
    case (state_r)
      RUN: begin
        if (redirect) begin
          pc_s    = target_s;
          instr_s = 32'h0000_0000;
          valid_s = 1'b0;
        end else if (stall) begin
          valid_s = valid_out;
        end else if (!ihit) begin
          valid_s = 1'b0;
        end else begin
          instr_s = imemload;
          npc_s   = pc_plus4_s;
          valid_s = 1'b1;
          // A fetched HALT keeps the PC on itself so a redirect can squash it cleanly.
          if (is_halt(imemload)) begin
            state_s = HALTED;
          end else begin
            pc_s = pc_plus4_s;
          end
        end
      end
      HALTED: begin
        if (redirect) begin
          pc_s    = target_s;
          instr_s = 32'h0000_0000;
          valid_s = 1'b0;
          state_s = RUN;
        end else if (stall) begin
          valid_s = valid_out;
        end else begin
          instr_s = 32'h0000_0000;
          valid_s = 1'b0;
        end
      end
      default: begin
        state_s = RUN;
      end
    endcase
  end

  // PC, state and IF/ID register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= RUN;
      pc_r      <= PC_INIT;
      instr_out <= 32'h0000_0000;
      npc_out   <= 32'h0000_0000;
      valid_out <= 1'b0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      instr_out <= instr_s;
      npc_out   <= npc_s;
      valid_out <= valid_s;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then randomized traffic,
// expected IF/ID contents come from a queue fed by a behavioural fetch model.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic [31:0] addr;
    logic        ren;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] npc_out;
  logic        valid_out;

  logic        rst2;
  logic        ihit2;
  logic [31:0] imemload2;
  logic        imemREN2;
  logic [31:0] imemaddr2;
  logic [31:0] instr_out2;
  logic [31:0] npc_out2;
  logic        valid_out2;

  int nchecks = 0;
  int nerrors = 0;

  exp_t        sb_q[$];
  logic [31:0] imem [256];

  // reference model state
  logic [31:0] m_pc;
  logic        m_halted;
  logic [31:0] m_instr;
  logic [31:0] m_npc;
  logic        m_valid;

  fetch_stage dut (
    .CLK(clk), .RST(rst), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_out(instr_out), .npc_out(npc_out), .valid_out(valid_out)
  );

  fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dut_wrap (
    .CLK(clk), .RST(rst2), .ihit(ihit2), .imemload(imemload2),
    .imemREN(imemREN2), .imemaddr(imemaddr2), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(32'h0000_0000),
    .instr_out(instr_out2), .npc_out(npc_out2), .valid_out(valid_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks = nchecks + 1;
    if (act !== exp) begin
      nerrors = nerrors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and record what the IF/ID register must hold afterwards.
  task automatic drive(input logic ih, input logic [31:0] ld, input logic st,
                       input logic rd, input logic [31:0] rpc);
    exp_t e;
    @(negedge clk);
    ihit = ih; imemload = ld; stall = st; redirect = rd; redirect_pc = rpc;
    if (rd) begin
      m_pc = {rpc[31:2], 2'b00};
      m_instr = 32'h0;
      m_valid = 1'b0;
      m_halted = 1'b0;
    end else if (st) begin
      m_valid = m_valid;
    end else if (m_halted) begin
      m_valid = 1'b0;
      m_instr = 32'h0;
    end else if (!ih) begin
      m_valid = 1'b0;
    end else begin
      m_instr = ld;
      m_npc = m_pc + 32'd4;
      m_valid = 1'b1;
      if (ld[31:26] == 6'h3F) m_halted = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
    e.instr = m_instr; e.npc = m_npc; e.valid = m_valid;
    e.addr = m_pc; e.ren = !m_halted;
    sb_q.push_back(e);
  endtask

  // Monitor: after every active edge compare the presented IF/ID state with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_instr", instr_out, e.instr);
        check("sb_npc", npc_out, e.npc);
        check("sb_valid", {31'd0, valid_out}, {31'd0, e.valid});
        check("sb_addr", imemaddr, e.addr);
        check("sb_ren", {31'd0, imemREN}, {31'd0, e.ren});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] rnd;
    rst = 1'b1; rst2 = 1'b1;
    ihit = 1'b0; imemload = 32'h0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    ihit2 = 1'b0; imemload2 = 32'h0;
    m_pc = 32'h0; m_halted = 1'b0; m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if ($urandom_range(0, 15) == 0) w[31:26] = 6'h3F;
      else if (w[31:26] == 6'h3F) w[31:26] = 6'h23;
      imem[i] = w;
    end
    #2;
    check("rst_instr", instr_out, 32'h0);
    check("rst_npc", npc_out, 32'h0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_addr", imemaddr, 32'h0);
    check("rst_ren", {31'd0, imemREN}, 32'd1);
    #1 rst = 1'b0;

    // T1 first fetch
    drive(1'b1, 32'h2001_0005, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #2;
    check("t1_instr", instr_out, 32'h2001_0005);
    check("t1_npc", npc_out, 32'd4);
    check("t1_valid", {31'd0, valid_out}, 32'd1);
    check("t1_addr", imemaddr, 32'd4);

    // T3 stall holds everything even with ihit
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, 1'b1, 1'b0, 32'h0);
      @(posedge clk); #2;
      check("t3_instr", instr_out, 32'h2001_0005);
      check("t3_addr", imemaddr, 32'd4);
    end
    drive(1'b1, 32'h8C22_0000, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #2;
    check("t3_resume_npc", npc_out, 32'd8);

    // T2 icache misses produce bubbles
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #2;
      check("t2_valid", {31'd0, valid_out}, 32'd0);
      check("t2_addr", imemaddr, 32'd8);
      check("t2_ren", {31'd0, imemREN}, 32'd1);
    end

    // T4 redirect beats stall and ihit, low bits dropped
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0043);
    @(posedge clk); #2;
    check("t4_addr", imemaddr, 32'h40);
    check("t4_valid", {31'd0, valid_out}, 32'd0);

    // T5 HALT handling
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h10);
    drive(1'b1, 32'hFC00_0000, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #2;
    check("t5_instr", instr_out, 32'hFC00_0000);
    check("t5_valid", {31'd0, valid_out}, 32'd1);
    check("t5_ren", {31'd0, imemREN}, 32'd0);
    check("t5_addr", imemaddr, 32'h10);
    drive(1'b1, $urandom, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #2;
    check("t5_stall_valid", {31'd0, valid_out}, 32'd1);
    drive(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #2;
    check("t5_consumed_valid", {31'd0, valid_out}, 32'd0);
    check("t5_consumed_instr", instr_out, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
    @(posedge clk); #2;
    check("t5_exit_ren", {31'd0, imemREN}, 32'd1);
    check("t5_exit_addr", imemaddr, 32'h40);

    // Randomized traffic against the memory image
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      drive($urandom_range(0, 3) != 0, imem[m_pc[9:2]], $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0, {22'd0, rnd[9:0]});
    end
    @(posedge clk); #2;

    // T6 PC wrap and asynchronous reset
    @(negedge clk);
    rst2 = 1'b0; ihit2 = 1'b1; imemload2 = 32'h0000_0020;
    @(posedge clk); #2;
    check("t6_npc", npc_out2, 32'h0);
    check("t6_addr", imemaddr2, 32'h0);
    check("t6_valid", {31'd0, valid_out2}, 32'd1);
    @(negedge clk);
    ihit2 = 1'b0;
    #2 rst2 = 1'b1;
    #1;
    check("t6_async_valid", {31'd0, valid_out2}, 32'd0);
    check("t6_async_instr", instr_out2, 32'h0);
    check("t6_async_addr", imemaddr2, 32'hFFFF_FFFC);
    check("t6_async_npc", npc_out2, 32'h0);

    if (sb_q.size() != 0) check("sb_drain", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
